beam_weight_mult: RTL

Per-channel complex beamforming weight multiplier. It takes one channel's AXI-Stream of complex baseband samples and multiplies every sample by a complex weight. The weight is held constant across a packet. Rounded, saturated products go to one input port of the four-channel summing stage, and four instances (channels 00, 01, 20, 21) sit directly upstream of that adder.

---
 rtl/beam_weight_mult.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/beam_weight_mult.sv
// Per-channel complex weight multiplier: 3-stage AXI-Stream pipeline.
// Weights switch only at packet boundaries; outputs are rounded and saturated.
module beam_weight_mult #(
    parameter int DATA_WIDTH   = 128,
    parameter int SAMPLE_WIDTH = 16,
    parameter int WEIGHT_WIDTH = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    input  logic [WEIGHT_WIDTH-1:0] weight_real,
    input  logic [WEIGHT_WIDTH-1:0] weight_imag,
    input  logic                    weight_load,
    output logic                    weight_pending,
    output logic [15:0]             sat_count,
    input  logic                    sat_clear
);
    localparam int NS  = DATA_WIDTH / (2 * SAMPLE_WIDTH);
    localparam int SMP = SAMPLE_WIDTH;
    localparam int WW  = WEIGHT_WIDTH;
    localparam int PW  = SMP + WW;
    localparam int SW  = PW + 1;
    localparam int SH  = WW - 1;
    localparam logic signed [SW-1:0] RND  = SW'(2 ** (WW - 2));
    localparam logic signed [SW-1:0] MAXV = SW'(2 ** (SMP - 1) - 1);
    localparam logic signed [SW-1:0] MINV = SW'(-(2 ** (SMP - 1)));
    localparam logic [WW-1:0] ONE_RE = {1'b0, {(WW - 1){1'b1}}};

    logic en;
    logic accept;
    logic use_pnd;

    logic signed [WW-1:0] act_re_q, act_re_d;
    logic signed [WW-1:0] act_im_q, act_im_d;
    logic signed [WW-1:0] pnd_re_q, pnd_re_d;
    logic signed [WW-1:0] pnd_im_q, pnd_im_d;
    logic                 pend_q, pend_d;
    logic                 in_pkt_q, in_pkt_d;
    logic signed [WW-1:0] sel_re, sel_im;

    logic                  s1_v_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic                  s1_last_q;
    logic signed [WW-1:0]  s1_wr_q, s1_wi_q;

    logic signed [SMP-1:0] smp_i [NS];
    logic signed [SMP-1:0] smp_q [NS];
    logic signed [PW-1:0]  p_ir_d [NS];
    logic signed [PW-1:0]  p_qi_d [NS];
    logic signed [PW-1:0]  p_ii_d [NS];
    logic signed [PW-1:0]  p_qr_d [NS];

    logic                  s2_v_q;
    logic                  s2_last_q;
    logic signed [PW-1:0]  p_ir_q [NS];
    logic signed [PW-1:0]  p_qi_q [NS];
    logic signed [PW-1:0]  p_ii_q [NS];
    logic signed [PW-1:0]  p_qr_q [NS];

    logic [SMP:0]          re_r [NS];
    logic [SMP:0]          im_r [NS];
    logic [DATA_WIDTH-1:0] out_d;
    logic                  osat_d;

    logic                  m_valid_q;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic                  m_last_q;
    logic                  m_sat_q;
    logic [15:0]           sat_cnt_q, sat_cnt_d;

    assign en            = !m_valid_q || m_axis_tready;
    assign s_axis_tready = en;
    assign accept        = s_axis_tvalid && en;
    // Pending weight is consumed by the next first beat or any idle edge.
    assign use_pnd       = !in_pkt_q && pend_q;
    assign sel_re        = use_pnd ? pnd_re_q : act_re_q;
    assign sel_im        = use_pnd ? pnd_im_q : act_im_q;

    always_comb begin
        act_re_d = act_re_q;
        act_im_d = act_im_q;
        pnd_re_d = pnd_re_q;
        pnd_im_d = pnd_im_q;
        pend_d   = pend_q;
        in_pkt_d = in_pkt_q;
        if (use_pnd) begin
            act_re_d = pnd_re_q;
            act_im_d = pnd_im_q;
            pend_d   = 1'b0;
        end
        if (weight_load) begin
            pnd_re_d = weight_real;
            pnd_im_d = weight_imag;
            pend_d   = 1'b1;
        end
        if (accept) begin
            in_pkt_d = !s_axis_tlast;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            act_re_q <= ONE_RE;
            act_im_q <= '0;
            pnd_re_q <= '0;
            pnd_im_q <= '0;
            pend_q   <= 1'b0;
            in_pkt_q <= 1'b0;
        end else begin
            act_re_q <= act_re_d;
            act_im_q <= act_im_d;
            pnd_re_q <= pnd_re_d;
            pnd_im_q <= pnd_im_d;
            pend_q   <= pend_d;
            in_pkt_q <= in_pkt_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_v_q    <= 1'b0;
            s1_data_q <= '0;
            s1_last_q <= 1'b0;
            s1_wr_q   <= '0;
            s1_wi_q   <= '0;
        end else if (en) begin
            s1_v_q    <= accept;
            s1_data_q <= s_axis_tdata;
            s1_last_q <= s_axis_tlast;
            s1_wr_q   <= sel_re;
            s1_wi_q   <= sel_im;
        end
    end

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            smp_i[k]  = s1_data_q[2*SMP*k +: SMP];
            smp_q[k]  = s1_data_q[2*SMP*k+SMP +: SMP];
            p_ir_d[k] = PW'(smp_i[k]) * PW'(s1_wr_q);
            p_qi_d[k] = PW'(smp_q[k]) * PW'(s1_wi_q);
            p_ii_d[k] = PW'(smp_i[k]) * PW'(s1_wi_q);
            p_qr_d[k] = PW'(smp_q[k]) * PW'(s1_wr_q);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_v_q    <= 1'b0;
            s2_last_q <= 1'b0;
            for (int k = 0; k < NS; k++) begin
                p_ir_q[k] <= '0;
                p_qi_q[k] <= '0;
                p_ii_q[k] <= '0;
                p_qr_q[k] <= '0;
            end
        end else if (en) begin
            s2_v_q    <= s1_v_q;
            s2_last_q <= s1_last_q;
            for (int k = 0; k < NS; k++) begin
                p_ir_q[k] <= p_ir_d[k];
                p_qi_q[k] <= p_qi_d[k];
                p_ii_q[k] <= p_ii_d[k];
                p_qr_q[k] <= p_qr_d[k];
            end
        end
    end

    // Result bit SMP flags saturation; low bits are the clamped value.
    function automatic logic [SMP:0] rnd_sat(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] r;
        r = (s + RND) >>> SH;
        if (r > MAXV) begin
            rnd_sat = {1'b1, MAXV[SMP-1:0]};
        end else if (r < MINV) begin
            rnd_sat = {1'b1, MINV[SMP-1:0]};
        end else begin
            rnd_sat = {1'b0, r[SMP-1:0]};
        end
    endfunction

    always_comb begin
        out_d  = '0;
        osat_d = 1'b0;
        for (int k = 0; k < NS; k++) begin
            re_r[k] = rnd_sat(SW'(p_ir_q[k]) - SW'(p_qi_q[k]));
            im_r[k] = rnd_sat(SW'(p_ii_q[k]) + SW'(p_qr_q[k]));
            out_d[2*SMP*k +: SMP]     = re_r[k][SMP-1:0];
            out_d[2*SMP*k+SMP +: SMP] = im_r[k][SMP-1:0];
            osat_d = osat_d | re_r[k][SMP] | im_r[k][SMP];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_sat_q   <= 1'b0;
        end else if (en) begin
            m_valid_q <= s2_v_q;
            m_data_q  <= out_d;
            m_last_q  <= s2_last_q;
            m_sat_q   <= osat_d;
        end
    end

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clear) begin
            sat_cnt_d = '0;
        end else if (m_valid_q && m_axis_tready && m_sat_q &&
                     (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign m_axis_tvalid  = m_valid_q;
    assign m_axis_tdata   = m_data_q;
    assign m_axis_tlast   = m_last_q;
    assign weight_pending = pend_q;
    assign sat_count      = sat_cnt_q;

endmodule
